if_stage: RTL
=============

Name: if_stage

Overview:
Instruction-fetch stage sitting directly upstream of the decode stage; owns the fetch PC.
- Issues word reads to a synchronous instruction memory with fixed 1-cycle read latency.
- Buffers returned {instr, PC} pairs in a small FIFO and presents them to decode over a valid/ready handshake.
- Supports redirect (branch/jump target, which also flushes) and halts fetching after the halt instruction.

Parameters:
RESET_PC, 32'h0000_0000, fetch address after reset
DEPTH, 4, output FIFO entries; power of two, >=3 for full throughput
HALT_INSTR, 32'hdead10cc, instruction word that stops fetching

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  reset, asynchronous, active-low
redirect  in  1  redirect/flush request from execute
redirect_pc  in  32  new fetch address, valid when redirect=1
imem_req  out  1  read request this cycle
imem_addr  out  32  word address, {fetch_pc[31:2],2'b00}
imem_rdata  in  32  read data, valid the cycle after a request
out_instr  out  32  instruction at FIFO head
out_PC  out  32  PC of out_instr
out_valid  out  1  FIFO head valid
out_ready  in  1  decode can accept
halted  out  1  halt instruction has been enqueued; fetching stopped

Behaviour:
- Reset (rst_n low, takes effect immediately):
  - fetch_pc=RESET_PC; FIFO empty (count=0); inflight=0; halted=0.
  - out_valid=0; imem_req=0.
  - out_instr and out_PC read 0.
- Issue condition: imem_req = rst_n & ~redirect & ~halted & (count + inflight < DEPTH).
  - count is the registered FIFO occupancy. No combinational path from out_ready to imem_req.
  - On issue: inflight<=1, inflight_pc<=fetch_pc, fetch_pc<=fetch_pc+4 (wraps modulo 2^32).
  - If not issuing: inflight<=0.
- Response: in the cycle after an issue, the pair {imem_rdata, inflight_pc} is pushed into the FIFO unless it is dropped.
  - The response is dropped if redirect=1 in the response cycle.
  - The response is dropped if a redirect occurred in the issue cycle (no issue happens then).
  - The response is dropped if halted=1 at the start of the response cycle.
- Halt: when a pushed instruction equals HALT_INSTR, halted<=1.
  - The halt instruction itself is enqueued and delivered.
  - The response following it, issued in the same cycle, is dropped.
  - No further requests are issued.
- Output handshake:
  - out_valid = (count!=0); out_instr and out_PC are the FIFO head.
  - Pop on out_valid & out_ready.
  - Push and pop in the same cycle are both performed; count is unchanged.
  - Head data is stable while out_valid=1 and out_ready=0.
- Redirect (highest priority, single cycle):
  - FIFO cleared and count<=0. A simultaneous pop or push is ignored.
  - Any inflight response is discarded; halted<=0.
  - fetch_pc <= {redirect_pc[31:2],2'b00}.
  - imem_req=0 in the redirect cycle; the first request to the new PC is issued the next cycle.
- Timing:
  - Latency from issue to out_valid is 2 cycles.
  - Sustained rate is 1 instr/cycle when out_ready=1 and DEPTH>=3.
- Full FIFO: issue stalls by credit, so overflow is impossible. A push into a full FIFO is an assertion failure.
- Empty FIFO: a pop while out_valid=0 has no effect.

Decomposition:
- Shared package: RESET_PC_DEFAULT, HALT_INSTR (32'hdead10cc, shared with decode's done detection), typedef pc_t (logic [31:0]).
- One sub-module, fetch_fifo:
  - Parameter DEPTH; 64-bit entries {PC, instr}.
  - Ports: push, pop, clear, count, head.
  - Asynchronous active-low reset.
- Top-level if_stage holds fetch_pc, inflight, inflight_pc, halted and the issue/drop logic.

Test Plan:
1. Release reset with out_ready=1 and a memory returning rdata=addr.
   - imem_req=1 in the first cycle with addr 0x0.
   - out_valid first asserts 2 cycles later.
   - out_PC=0x0,0x4,0x8,... one per cycle, out_instr==out_PC.
2. Hold out_ready=0 for 10 cycles.
   - count reaches 4 and imem_req drops to 0.
   - out_PC holds 0x0.
   - On release: 0x0,0x4,0x8,0xC,0x10,... with no gap, duplicate or loss.
3. Pulse redirect with redirect_pc=0x100 while count=3 and one response is inflight.
   - Next cycle: out_valid=0 and imem_req=1 with addr 0x100.
   - Outputs then 0x100,0x104; no 0x0–0x10 entries appear.
4. Memory word at 0x8 is 0xdead10cc.
   - Delivered with out_PC=0x8 and halted=1.
   - Response for 0xC dropped; imem_req stays 0.
   - A later redirect to 0x0 clears halted and resumes fetch at 0x0.
5. Assert rst_n low mid-burst, asynchronous to clk.
   - out_valid=0 and imem_req=0 immediately.
   - After release, fetch restarts at RESET_PC.
6. Redirect to 0x103.
   - imem_addr=0x100 and out_PC=0x100.
   - A redirect in the same cycle as a pop leaves count=0 the next cycle.

Source files
------------

// File: rtl/if_stage_pkg.sv
// Constants and types shared by the fetch stage and its neighbours.
package if_stage_pkg;
    typedef logic [31:0] pc_t;

    localparam pc_t         RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] HALT_INSTR       = 32'hdead10cc;
endpackage

// File: rtl/fetch_fifo.sv
// Output buffer of {PC, instr} pairs for the fetch stage.
// Clear has priority over push and pop.
module fetch_fifo #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [63:0]              push_data,
    input  logic                     pop,
    input  logic                     clear,
    output logic [$clog2(DEPTH):0]   count,
    output logic [63:0]              head
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [63:0]   mem_q [DEPTH];
    logic [63:0]   mem_d [DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_pop;

    // A pop on an empty buffer is a no-op.
    assign do_pop = pop && (count_q != '0);

    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (clear) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            count_d = count_q + CW'(push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

    overflow_a: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && !clear && !do_pop && (count_q == CW'(DEPTH))));
endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the fetch PC, issues 1-cycle-latency memory
// reads under FIFO credit, and hands {instr, PC} to decode.
module if_stage
    import if_stage_pkg::*;
#(
    parameter pc_t         RESET_PC   = RESET_PC_DEFAULT,
    parameter int unsigned DEPTH      = 4,
    parameter logic [31:0] HALT_INSTR = if_stage_pkg::HALT_INSTR
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] out_instr,
    output logic [31:0] out_PC,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        halted
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    pc_t           fetch_pc_q, fetch_pc_d;
    pc_t           inflight_pc_q, inflight_pc_d;
    logic          inflight_q, inflight_d;
    logic          halted_q, halted_d;
    logic [CW-1:0] count;
    logic [CW:0]   credit;
    logic [63:0]   head;
    logic          issue;
    logic          push;

    // Credit counts the in-flight read so the FIFO can never overflow;
    // it uses registered occupancy only, so out_ready never reaches imem_req.
    always_comb begin
        credit = (CW+1)'(count) + (CW+1)'(inflight_q);
        issue  = rst_n && !redirect && !halted_q && (credit < (CW+1)'(DEPTH));
        push   = inflight_q && !redirect && !halted_q;

        fetch_pc_d    = fetch_pc_q;
        inflight_d    = issue;
        inflight_pc_d = inflight_pc_q;
        halted_d      = halted_q;
        if (redirect) begin
            fetch_pc_d = redirect_pc & ~32'h3;
            halted_d   = 1'b0;
        end else begin
            if (issue) begin
                fetch_pc_d    = fetch_pc_q + 32'd4;
                inflight_pc_d = fetch_pc_q;
            end
            if (push && (imem_rdata == HALT_INSTR)) begin
                halted_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q    <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            halted_q      <= 1'b0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            halted_q      <= halted_d;
        end
    end

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data ({inflight_pc_q, imem_rdata}),
        .pop       (out_ready),
        .clear     (redirect),
        .count     (count),
        .head      (head)
    );

    assign imem_req  = issue;
    assign imem_addr = fetch_pc_q & ~32'h3;
    assign out_valid = (count != '0);
    assign out_PC    = head[63:32];
    assign out_instr = head[31:0];
    assign halted    = halted_q;
endmodule
